// File: rtl/mul12u_err_monitor_pkg.sv
// Shared widths, FSM states and pipeline bundles
// for the 12x12 multiplier error monitor.
package mul12_eval_pkg;

  localparam int W     = 12;
  localparam int PW    = 2 * W;
  localparam int DW    = PW + 1;
  localparam int N_MAX = 65536;

  // Counter width able to hold the value n itself.
  function automatic int cnt_w_f(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CNT_W = cnt_w_f(N_MAX);
  localparam int ACC_W = PW + CNT_W;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  typedef struct packed {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [PW-1:0] exact;
    logic [PW-1:0] approx;
  } s1_t;

  typedef struct packed {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [DW-1:0] d;
    logic [PW-1:0] absd;
  } s2_t;

endpackage

// File: rtl/mul12u_err_monitor_if.sv
// Sample stream from the multiplier under test:
// operands, approximate product, valid/ready.
interface mul12u_err_monitor_if;
  import mul12_eval_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [PW-1:0] in_approx;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output in_approx,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  in_approx,
    output in_ready
  );

endinterface

// File: rtl/mul12u_err_monitor_err_stage.sv
// Two-stage datapath: exact product (S1), then
// signed difference and its magnitude (S2).
module mul12_err_stage
  import mul12_eval_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_valid,
  input  logic [W-1:0]  i_a,
  input  logic [W-1:0]  i_b,
  input  logic [PW-1:0] i_approx,
  output logic          o_valid,
  output logic          o_pending,
  output s2_t           o_s2
);

  s1_t                  r_s1;
  logic                 r_s1_v;
  s2_t                  r_s2;
  logic                 r_s2_v;

  logic [PW-1:0]        w_exact;
  logic signed [DW-1:0] w_d;
  logic [PW-1:0]        w_abs;

  assign w_exact = PW'(i_a) * PW'(i_b);

  assign w_d = $signed({1'b0, r_s1.approx})
             - $signed({1'b0, r_s1.exact});

  assign w_abs = w_d[DW-1] ? PW'(-w_d) : PW'(w_d);

  // S1: capture operands and the exact product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v <= 1'b0;
      r_s1   <= '0;
    end else begin
      r_s1_v <= i_valid & ~i_flush;
      if (i_valid) begin
        r_s1.a      <= i_a;
        r_s1.b      <= i_b;
        r_s1.exact  <= w_exact;
        r_s1.approx <= i_approx;
      end
    end
  end

  // S2: signed error and magnitude.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_v <= 1'b0;
      r_s2   <= '0;
    end else begin
      r_s2_v <= r_s1_v & ~i_flush;
      if (r_s1_v) begin
        r_s2.a    <= r_s1.a;
        r_s2.b    <= r_s1.b;
        r_s2.d    <= w_d;
        r_s2.absd <= w_abs;
      end
    end
  end

  assign o_valid   = r_s2_v;
  assign o_pending = r_s1_v | r_s2_v;
  assign o_s2      = r_s2;

endmodule

// File: rtl/mul12u_err_monitor.sv
// Error-statistics collector: run FSM plus
// |err|, bias, worst-case and count accumulators.
module mul12u_err_monitor
  import mul12_eval_pkg::*;
#(
  parameter int N_SAMPLES = 4096
)
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  mul12u_err_monitor_if.slave     s_in,
  output logic                    busy,
  output logic                    done,
  output logic [ACC_W-1:0]        sum_abs_err,
  output logic signed [ACC_W:0]   sum_err,
  output logic [PW-1:0]           max_err,
  output logic [W-1:0]            max_a,
  output logic [W-1:0]            max_b,
  output logic [CNT_W-1:0]        err_cnt,
  output logic [CNT_W-1:0]        sample_cnt
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(N_SAMPLES - 1);

  state_e              r_state;
  state_e              w_next;

  logic [ACC_W-1:0]    r_sum_abs;
  logic [ACC_W:0]      r_sum_err;
  logic [PW-1:0]       r_max;
  logic [W-1:0]        r_max_a;
  logic [W-1:0]        r_max_b;
  logic [CNT_W-1:0]    r_err_cnt;
  logic [CNT_W-1:0]    r_smp_cnt;

  logic                w_accept;
  logic                w_last;
  logic                w_s2_v;
  logic                w_pending;
  s2_t                 w_s2;
  logic [ACC_W:0]      w_d_ext;

  assign s_in.in_ready = (r_state == RUN);

  // A restart takes priority over a same-cycle sample.
  assign w_accept = s_in.in_valid & s_in.in_ready & ~start;
  assign w_last   = w_accept & (r_smp_cnt == LAST);

  assign w_d_ext = {{(ACC_W + 1 - DW){w_s2.d[DW-1]}}, w_s2.d};

  mul12_err_stage u_stage (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (start),
    .i_valid   (w_accept),
    .i_a       (s_in.in_a),
    .i_b       (s_in.in_b),
    .i_approx  (s_in.in_approx),
    .o_valid   (w_s2_v),
    .o_pending (w_pending),
    .o_s2      (w_s2)
  );

  // Run state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state: start always (re)enters RUN.
  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = RUN;
    end else begin
      unique case (r_state)
        IDLE:  w_next = IDLE;
        RUN:   if (w_last) w_next = DRAIN;
        DRAIN: if (!w_pending) w_next = DONE;
        DONE:  w_next = IDLE;
      endcase
    end
  end

  // Accumulators: cleared by start, updated from S2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum_abs <= '0;
      r_sum_err <= '0;
      r_max     <= '0;
      r_max_a   <= '0;
      r_max_b   <= '0;
      r_err_cnt <= '0;
      r_smp_cnt <= '0;
    end else if (start) begin
      r_sum_abs <= '0;
      r_sum_err <= '0;
      r_max     <= '0;
      r_max_a   <= '0;
      r_max_b   <= '0;
      r_err_cnt <= '0;
      r_smp_cnt <= '0;
    end else begin
      if (w_accept)
        r_smp_cnt <= r_smp_cnt + CNT_W'(1);
      if (w_s2_v) begin
        r_sum_abs <= r_sum_abs + ACC_W'(w_s2.absd);
        r_sum_err <= r_sum_err + w_d_ext;
        if (w_s2.absd != '0)
          r_err_cnt <= r_err_cnt + CNT_W'(1);
        // Strictly greater: ties keep the earliest operands.
        if (w_s2.absd > r_max) begin
          r_max   <= w_s2.absd;
          r_max_a <= w_s2.a;
          r_max_b <= w_s2.b;
        end
      end
    end
  end

  assign busy        = (r_state == RUN) | (r_state == DRAIN);
  assign done        = (r_state == DONE);
  assign sum_abs_err = r_sum_abs;
  assign sum_err     = $signed(r_sum_err);
  assign max_err     = r_max;
  assign max_a       = r_max_a;
  assign max_b       = r_max_b;
  assign err_cnt     = r_err_cnt;
  assign sample_cnt  = r_smp_cnt;

endmodule

// File: tb/tb_mul12u_err_monitor.sv
// Bench for mul12u_err_monitor: directed scenarios
// plus random runs against a plain-arithmetic model.
module tb_mul12u_err_monitor;
  import mul12_eval_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [2:0]    t_start = '0;
  int            sel = 0;
  logic          t_valid = 1'b0;
  logic [W-1:0]  t_a = '0;
  logic [W-1:0]  t_b = '0;
  logic [PW-1:0] t_ap = '0;
  int            tests = 0;
  int            fails = 0;
  int            n;

  always #5 clk = ~clk;

  mul12u_err_monitor_if if0 ();
  mul12u_err_monitor_if if1 ();
  mul12u_err_monitor_if if2 ();

  assign if0.in_valid  = t_valid;
  assign if0.in_a      = t_a;
  assign if0.in_b      = t_b;
  assign if0.in_approx = t_ap;
  assign if1.in_valid  = t_valid;
  assign if1.in_a      = t_a;
  assign if1.in_b      = t_b;
  assign if1.in_approx = t_ap;
  assign if2.in_valid  = t_valid;
  assign if2.in_a      = t_a;
  assign if2.in_b      = t_b;
  assign if2.in_approx = t_ap;

  logic                  w_rdy  [3];
  logic                  w_busy [3];
  logic                  w_done [3];
  logic [ACC_W-1:0]      w_sabs [3];
  logic signed [ACC_W:0] w_serr [3];
  logic [PW-1:0]         w_max  [3];
  logic [W-1:0]          w_ma   [3];
  logic [W-1:0]          w_mb   [3];
  logic [CNT_W-1:0]      w_ec   [3];
  logic [CNT_W-1:0]      w_sc   [3];

  assign w_rdy[0] = if0.in_ready;
  assign w_rdy[1] = if1.in_ready;
  assign w_rdy[2] = if2.in_ready;

  mul12u_err_monitor #(.N_SAMPLES(4)) u4 (
    .clk(clk), .rst(rst), .start(t_start[0]),
    .s_in(if0),
    .busy(w_busy[0]), .done(w_done[0]),
    .sum_abs_err(w_sabs[0]), .sum_err(w_serr[0]),
    .max_err(w_max[0]), .max_a(w_ma[0]), .max_b(w_mb[0]),
    .err_cnt(w_ec[0]), .sample_cnt(w_sc[0])
  );

  mul12u_err_monitor #(.N_SAMPLES(16)) u16 (
    .clk(clk), .rst(rst), .start(t_start[1]),
    .s_in(if1),
    .busy(w_busy[1]), .done(w_done[1]),
    .sum_abs_err(w_sabs[1]), .sum_err(w_serr[1]),
    .max_err(w_max[1]), .max_a(w_ma[1]), .max_b(w_mb[1]),
    .err_cnt(w_ec[1]), .sample_cnt(w_sc[1])
  );

  mul12u_err_monitor #(.N_SAMPLES(65536)) u64k (
    .clk(clk), .rst(rst), .start(t_start[2]),
    .s_in(if2),
    .busy(w_busy[2]), .done(w_done[2]),
    .sum_abs_err(w_sabs[2]), .sum_err(w_serr[2]),
    .max_err(w_max[2]), .max_a(w_ma[2]), .max_b(w_mb[2]),
    .err_cnt(w_ec[2]), .sample_cnt(w_sc[2])
  );

  function automatic logic [63:0] sx(
    input logic signed [ACC_W:0] v);
    return {{(63 - ACC_W){v[ACC_W]}}, v};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string p,
                         input longint sa, input longint se,
                         input longint mx, input longint ma,
                         input longint mb, input longint ec,
                         input longint sc);
    chk({p, ".sum_abs"}, 64'(w_sabs[sel]), sa);
    chk({p, ".sum_err"}, sx(w_serr[sel]), se);
    chk({p, ".max_err"}, 64'(w_max[sel]), mx);
    chk({p, ".max_a"},   64'(w_ma[sel]), ma);
    chk({p, ".max_b"},   64'(w_mb[sel]), mb);
    chk({p, ".err_cnt"}, 64'(w_ec[sel]), ec);
    chk({p, ".smp_cnt"}, 64'(w_sc[sel]), sc);
  endtask

  // Called at a negedge; returns at the negedge after start.
  task automatic go();
    t_start[sel] = 1'b1;
    @(negedge clk);
    t_start = '0;
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input int a, input int b, input int ap);
    int k = 0;
    t_valid = 1'b1;
    t_a = W'(a);
    t_b = W'(b);
    t_ap = PW'(ap);
    while (!w_rdy[sel] && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("send_ready", 64'(w_rdy[sel]), 64'd1);
    @(negedge clk);
    t_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!w_done[sel] && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", 64'(w_done[sel]), 64'd1);
  endtask

  task automatic send_s2();
    send(3, 5, 15);
    send(100, 100, 9984);
    send(2, 2, 10);
    send(64, 64, 4080);
  endtask

  task automatic rnd_run(input bit gaps);
    int     ra [16];
    int     rb [16];
    int     rp [16];
    longint ex, e, ae;
    longint sa = 0, se = 0, mx = 0;
    longint ma = 0, mb = 0, ec = 0;
    for (int i = 0; i < 16; i++) begin
      ra[i] = int'($urandom_range(0, 4095));
      rb[i] = int'($urandom_range(0, 4095));
      ex = longint'(ra[i]) * longint'(rb[i]);
      case ($urandom_range(0, 3))
        0: e = 0;
        1, 2: e = longint'($urandom_range(0, 600)) - 300;
        default: e = longint'($urandom_range(0, 16777215)) - ex;
      endcase
      if (ex + e < 0) e = -ex;
      if (ex + e > 16777215) e = 16777215 - ex;
      rp[i] = int'(ex + e);
      ae = (e < 0) ? -e : e;
      sa += ae;
      se += e;
      if (e != 0) ec++;
      if (ae > mx) begin
        mx = ae;
        ma = ra[i];
        mb = rb[i];
      end
    end
    go();
    for (int i = 0; i < 16; i++) begin
      send(ra[i], rb[i], rp[i]);
      if (gaps && $urandom_range(0, 1) == 1)
        @(negedge clk);
    end
    wait_done(10, n);
    chk_all("rnd", sa, se, mx, ma, mb, ec, 16);
  endtask

  initial begin
    longint big;

    // Reset values
    #1 rst = 1'b1;
    #2;
    sel = 0;
    chk("rst.in_ready", 64'(w_rdy[0]), 0);
    chk("rst.busy", 64'(w_busy[0]), 0);
    chk("rst.done", 64'(w_done[0]), 0);
    chk_all("rst", 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed N=4 run
    go();
    chk("s2.busy", 64'(w_busy[0]), 1);
    send_s2();
    wait_done(10, n);
    chk("s2.done_lat", 64'(n), 3);
    chk_all("s2", 38, -26, 16, 100, 100, 3, 4);
    @(negedge clk);
    chk("s2.done_pulse", 64'(w_done[0]), 0);
    chk("s2.idle_busy", 64'(w_busy[0]), 0);

    // Gapped stream, valid held through drain
    go();
    send(3, 5, 15);
    @(negedge clk);
    send(100, 100, 9984);
    @(negedge clk);
    send(2, 2, 10);
    @(negedge clk);
    send(64, 64, 4080);
    t_valid = 1'b1;
    t_a = 12'd1;
    t_b = 12'd1;
    t_ap = 24'd77;
    chk("drain.ready", 64'(w_rdy[0]), 0);
    chk("drain.busy", 64'(w_busy[0]), 1);
    wait_done(10, n);
    chk_all("gap", 38, -26, 16, 100, 100, 3, 4);
    repeat (4) @(negedge clk);
    t_valid = 1'b0;
    chk_all("hold", 38, -26, 16, 100, 100, 3, 4);

    // Restart mid-run drops in-flight samples
    go();
    send(100, 100, 9984);
    send(2, 2, 10);
    t_valid = 1'b1;
    t_a = 12'd1;
    t_b = 12'd1;
    t_ap = 24'd100;
    go();
    t_valid = 1'b0;
    chk_all("rst_clr", 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk_all("rst_drop", 0, 0, 0, 0, 0, 0, 0);
    send_s2();
    wait_done(10, n);
    chk_all("rerun", 38, -26, 16, 100, 100, 3, 4);

    // Async reset mid-run
    go();
    send(100, 100, 9984);
    send(2, 2, 10);
    t_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst.ready", 64'(w_rdy[0]), 0);
    chk("arst.busy", 64'(w_busy[0]), 0);
    chk_all("arst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post.busy", 64'(w_busy[0]), 0);
    chk("post.done", 64'(w_done[0]), 0);
    chk("post.smp", 64'(w_sc[0]), 0);
    t_valid = 1'b0;

    // Exact-only stream, N=16
    sel = 1;
    go();
    for (int i = 0; i < 16; i++)
      send(4095, 4095, 16769025);
    wait_done(10, n);
    chk_all("exact", 0, 0, 0, 0, 0, 0, 16);

    // Random runs against the model
    rnd_run(1'b0);
    rnd_run(1'b1);
    rnd_run(1'b1);

    // Worst case width, N=65536
    sel = 2;
    go();
    t_valid = 1'b1;
    t_a = 12'd4095;
    t_b = 12'd4095;
    t_ap = 24'd0;
    wait_done(70000, n);
    t_valid = 1'b0;
    big = 65536 * longint'(16769025);
    chk_all("wce", big, -big, 16769025,
            4095, 4095, 65536, 65536);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
